lsu_mem_master: RTL

- MEM-stage initiator for the RV32I data memory.
- Accepts one load/store request from the pipeline and drives the memory's read/write port: mem_read/mem_write, read_part/write_part, byte address and write data.
- Returns the sign- or zero-extended load result.
- Accesses the memory cannot do natively are split into legal sub-accesses: misaligned loads become two word reads, misaligned stores become a sequence of byte writes.

---
 rtl/lsu_pkg.sv | 96 +++++++++
 rtl/lsu_load_align.sv | 36 +++
 rtl/lsu_mem_master.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared encodings, state type and size/alignment helpers
//                for the RV32I MEM-stage memory master.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // RV32I load/store funct3 values
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Memory read_part encodings
    localparam logic [2:0] RP_WORD   = 3'd0;
    localparam logic [2:0] RP_HALF_S = 3'd1;
    localparam logic [2:0] RP_HALF_U = 3'd2;
    localparam logic [2:0] RP_BYTE_S = 3'd3;
    localparam logic [2:0] RP_BYTE_U = 3'd4;

    // Memory write_part encodings
    localparam logic [1:0] WP_WORD = 2'd0;
    localparam logic [1:0] WP_HALF = 2'd1;
    localparam logic [1:0] WP_BYTE = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LD0  = 3'd1,
        S_LD1  = 3'd2,
        S_ST   = 3'd3,
        S_STB  = 3'd4,
        S_RESP = 3'd5
    } lsu_state_e;

    // Access size in bytes; 0 for encodings that carry no size
    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        logic [2:0] size;
        case (funct3)
            F3_B, F3_BU: size = 3'd1;
            F3_H, F3_HU: size = 3'd2;
            F3_W:        size = 3'd4;
            default:     size = 3'd0;
        endcase
        return size;
    endfunction

    // Loads accept all five widths; stores only the signed encodings
    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        if (we) begin
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            ok = (size_of(funct3) != 3'd0);
        end
        return ok;
    endfunction

    // True when the memory can service the access natively
    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] off);
        logic ok;
        case (size_of(funct3))
            3'd1:    ok = 1'b1;
            3'd2:    ok = ~off[0];
            3'd4:    ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] native_read_part(input logic [2:0] funct3);
        logic [2:0] part;
        case (funct3)
            F3_B:    part = RP_BYTE_S;
            F3_BU:   part = RP_BYTE_U;
            F3_H:    part = RP_HALF_S;
            F3_HU:   part = RP_HALF_U;
            default: part = RP_WORD;
        endcase
        return part;
    endfunction

    function automatic logic [1:0] native_write_part(input logic [2:0] funct3);
        logic [1:0] part;
        case (funct3)
            F3_B:    part = WP_BYTE;
            F3_H:    part = WP_HALF;
            default: part = WP_WORD;
        endcase
        return part;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_load_align
//  Description : Combinational load merger. Shifts the {hi,lo} word pair
//                right by the byte offset, keeps the access width and
//                sign/zero-extends it according to funct3.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [63:0] w_shifted;

    // Bring the addressed byte to bit 0, then extend per load type
    always_comb begin
        w_shifted = {i_hi, i_lo} >> {i_off, 3'b000};
        o_result  = '0;
        case (i_funct3)
            F3_B:    o_result = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_BU:   o_result = {24'h0, w_shifted[7:0]};
            F3_H:    o_result = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_HU:   o_result = {16'h0, w_shifted[15:0]};
            F3_W:    o_result = w_shifted[31:0];
            default: o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_master
//  Description : RV32I MEM-stage memory initiator. Accepts one load/store,
//                drives the memory port, splits misaligned loads into two
//                word reads and misaligned stores into byte writes, and
//                returns the extended load result with a one-cycle pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_read_part,
    output logic [1:0]        mem_write_part,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    lsu_state_e        r_state_q, w_state_d;
    logic              r_we_q, w_we_d;
    logic [2:0]        r_funct3_q, w_funct3_d;
    logic [ADDR_W-1:0] r_addr_q, w_addr_d;
    logic [DATA_W-1:0] r_wdata_q, w_wdata_d;
    logic [DATA_W-1:0] r_lo_q, w_lo_d;
    logic [DATA_W-1:0] r_rdata_q, w_rdata_d;
    logic              r_err_q, w_err_d;
    logic [1:0]        r_cnt_q, w_cnt_d;

    logic [1:0]        w_off;
    logic [2:0]        w_size;
    logic              w_aligned;
    logic              w_needs_hi;
    logic [3:0]        w_span;
    logic [ADDR_W-1:0] w_word_addr;

    logic [31:0]       w_al_hi;
    logic [31:0]       w_al_lo;
    logic [1:0]        w_al_off;
    logic [2:0]        w_al_f3;
    logic [31:0]       w_al_result;

    // Properties of the captured request used by every non-idle state
    always_comb begin
        w_off       = r_addr_q[1:0];
        w_size      = size_of(r_funct3_q);
        w_aligned   = is_aligned(r_funct3_q, w_off);
        w_span      = {2'b00, w_off} + {1'b0, w_size};
        w_needs_hi  = (w_span > 4'd4);
        w_word_addr = {r_addr_q[ADDR_W-1:2], 2'b00};
    end

    // Feed the merger: native reads arrive already extended, so they pass
    // through as a word at offset 0; split reads merge the captured lo word
    always_comb begin
        w_al_hi  = '0;
        w_al_lo  = mem_data_out;
        w_al_off = w_off;
        w_al_f3  = r_funct3_q;
        if (r_state_q == S_LD1) begin
            w_al_hi = mem_data_out;
            w_al_lo = r_lo_q;
        end else if (w_aligned) begin
            w_al_off = 2'b00;
            w_al_f3  = F3_W;
        end
    end

    lsu_load_align u_load_align (
        .i_hi     (w_al_hi),
        .i_lo     (w_al_lo),
        .i_off    (w_al_off),
        .i_funct3 (w_al_f3),
        .o_result (w_al_result)
    );

    // Next-state and capture logic
    always_comb begin
        w_state_d  = r_state_q;
        w_we_d     = r_we_q;
        w_funct3_d = r_funct3_q;
        w_addr_d   = r_addr_q;
        w_wdata_d  = r_wdata_q;
        w_lo_d     = r_lo_q;
        w_rdata_d  = r_rdata_q;
        w_err_d    = r_err_q;
        w_cnt_d    = r_cnt_q;
        case (r_state_q)
            S_IDLE: begin
                if (req_valid) begin
                    w_we_d     = req_we;
                    w_funct3_d = req_funct3;
                    w_addr_d   = req_addr;
                    w_wdata_d  = req_wdata;
                    w_lo_d     = '0;
                    w_rdata_d  = '0;
                    w_err_d    = 1'b0;
                    w_cnt_d    = 2'd0;
                    if (!is_legal(req_we, req_funct3)) begin
                        w_err_d   = 1'b1;
                        w_state_d = S_RESP;
                    end else if (!req_we) begin
                        w_state_d = S_LD0;
                    end else if (is_aligned(req_funct3, req_addr[1:0])) begin
                        w_state_d = S_ST;
                    end else begin
                        w_state_d = S_STB;
                    end
                end
            end
            S_LD0: begin
                if (!w_aligned && w_needs_hi) begin
                    w_lo_d    = mem_data_out;
                    w_state_d = S_LD1;
                end else begin
                    w_rdata_d = w_al_result;
                    w_state_d = S_RESP;
                end
            end
            S_LD1: begin
                w_rdata_d = w_al_result;
                w_state_d = S_RESP;
            end
            S_ST: begin
                w_state_d = S_RESP;
            end
            S_STB: begin
                if ({1'b0, r_cnt_q} == (w_size - 3'd1)) begin
                    w_state_d = S_RESP;
                end else begin
                    w_cnt_d = r_cnt_q + 2'd1;
                end
            end
            S_RESP: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // State and capture registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= S_IDLE;
            r_we_q     <= 1'b0;
            r_funct3_q <= '0;
            r_addr_q   <= '0;
            r_wdata_q  <= '0;
            r_lo_q     <= '0;
            r_rdata_q  <= '0;
            r_err_q    <= 1'b0;
            r_cnt_q    <= 2'd0;
        end else begin
            r_state_q  <= w_state_d;
            r_we_q     <= w_we_d;
            r_funct3_q <= w_funct3_d;
            r_addr_q   <= w_addr_d;
            r_wdata_q  <= w_wdata_d;
            r_lo_q     <= w_lo_d;
            r_rdata_q  <= w_rdata_d;
            r_err_q    <= w_err_d;
            r_cnt_q    <= w_cnt_d;
        end
    end

    // Moore outputs decoded from the registered state and captured request
    always_comb begin
        req_ready      = (r_state_q == S_IDLE);
        resp_valid     = (r_state_q == S_RESP);
        resp_rdata     = (r_state_q == S_RESP) ? r_rdata_q : '0;
        resp_err       = (r_state_q == S_RESP) ? r_err_q : 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_read_part  = RP_WORD;
        mem_write_part = WP_WORD;
        mem_address    = '0;
        mem_data_in    = '0;
        case (r_state_q)
            S_LD0: begin
                mem_read = 1'b1;
                if (w_aligned) begin
                    mem_read_part = native_read_part(r_funct3_q);
                    mem_address   = r_addr_q;
                end else begin
                    mem_address   = w_word_addr;
                end
            end
            S_LD1: begin
                mem_read    = 1'b1;
                mem_address = w_word_addr + ADDR_W'(4);
            end
            S_ST: begin
                mem_write      = 1'b1;
                mem_write_part = native_write_part(r_funct3_q);
                mem_address    = r_addr_q;
                mem_data_in    = r_wdata_q;
            end
            S_STB: begin
                mem_write      = 1'b1;
                mem_write_part = WP_BYTE;
                mem_address    = r_addr_q + ADDR_W'(r_cnt_q);
                mem_data_in    = {{(DATA_W-8){1'b0}}, r_wdata_q[{r_cnt_q, 3'b000} +: 8]};
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire
